// File: rtl/exp_taylor_pipe.sv
// exp_taylor_pipe: fully pipelined fixed-point exp(x) by truncated Taylor
// series, one series term per stage. It has a valid/ready handshake with a
// global stall, and a side-band tag travels with each operand.
// Optional feature macro: EXP_SAT_EN. When it is defined, every width fit
// saturates and a per-operand sticky flag drives out_overflow. When it is
// undefined, fits wrap to the low W bits and out_overflow is tied to 0.
module exp_taylor_pipe #(
  parameter int W     = 16,
  parameter int F     = 12,
  parameter int TERMS = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_overflow
);

  // 1.0 in Q(W-F).F
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << F;

  // RECIP[k] = floor(2^F / k! + 0.5), packed with k=1 in the low slice.
  // The expression (2^(F+1)/k! + 1) >> 1 is the same rounding done in integers.
  function automatic logic [TERMS*W-1:0] build_recip();
    logic [TERMS*W-1:0] r;
    longint unsigned    fact;
    longint unsigned    q;
    r    = '0;
    fact = 64'd1;
    for (int unsigned k = 1; k <= TERMS; k++) begin
      fact = fact * 64'(k);
      q    = (((64'd1 << (F + 1)) / fact) + 64'd1) >> 1;
      r[(k-1)*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  localparam logic [TERMS*W-1:0] RECIP_ALL = build_recip();

  // Sign-extend a W-bit two's complement value to the 2W working width
  function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

`ifdef EXP_SAT_EN
  localparam logic signed [2*W-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic clips(input logic signed [2*W-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic logic [W-1:0] fit(input logic signed [2*W-1:0] v);
    if (v > SMAX) return SMAX[W-1:0];
    if (v < SMIN) return SMIN[W-1:0];
    return v[W-1:0];
  endfunction
`else
  function automatic logic [W-1:0] fit(input logic signed [2*W-1:0] v);
    return v[W-1:0];
  endfunction
`endif

  // Stage registers: index 0 is the accept stage, index k holds term k.
  // x and pow are not needed past the last stage, so they stop one short.
  logic [TERMS:0]   r_vld;
  logic [W-1:0]     r_x   [0:TERMS-1];
  logic [W-1:0]     r_pow [0:TERMS-1];
  logic [W-1:0]     r_sum [0:TERMS];
  logic [TAG_W-1:0] r_tag [0:TERMS];
`ifdef EXP_SAT_EN
  logic [TERMS:0]   r_ovf;
  logic             w_ov  [1:TERMS];
`endif

  logic signed [2*W-1:0] w_pp [1:TERMS];
  logic signed [2*W-1:0] w_pt [1:TERMS];
  logic signed [2*W-1:0] w_ps [1:TERMS];
  logic [W-1:0]          w_pow  [1:TERMS];
  logic [W-1:0]          w_term [1:TERMS];
  logic [W-1:0]          w_sum  [1:TERMS];
  logic                  w_stall;

  assign w_stall  = r_vld[TERMS] && !out_ready;
  assign in_ready = !w_stall;

  // Per-stage series arithmetic: next power, scaled term, running sum
  always_comb begin
    for (int unsigned k = 1; k <= TERMS; k++) begin
      w_pp[k]   = sx(r_pow[k-1]) * sx(r_x[k-1]);
      w_pow[k]  = fit(w_pp[k] >>> F);
      w_pt[k]   = sx(w_pow[k]) * sx(RECIP_ALL[(k-1)*W +: W]);
      w_term[k] = fit(w_pt[k] >>> F);
      w_ps[k]   = sx(r_sum[k-1]) + sx(w_term[k]);
      w_sum[k]  = fit(w_ps[k]);
`ifdef EXP_SAT_EN
      w_ov[k]   = r_ovf[k-1] | clips(w_pp[k] >>> F) | clips(w_pt[k] >>> F)
                | clips(w_ps[k]);
`endif
    end
  end

  // Pipeline advance: every stage moves together unless the output is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < TERMS; k++) begin
        r_x[k]   <= '0;
        r_pow[k] <= '0;
      end
      for (int unsigned k = 0; k <= TERMS; k++) begin
        r_sum[k] <= '0;
        r_tag[k] <= '0;
      end
`ifdef EXP_SAT_EN
      r_ovf <= '0;
`endif
    end else if (!w_stall) begin
      r_vld[0] <= in_valid;
      r_x[0]   <= in_x;
      r_pow[0] <= ONE;
      r_sum[0] <= ONE;
      r_tag[0] <= in_tag;
      for (int unsigned k = 1; k <= TERMS; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_sum[k] <= w_sum[k];
        r_tag[k] <= r_tag[k-1];
      end
      for (int unsigned k = 1; k < TERMS; k++) begin
        r_x[k]   <= r_x[k-1];
        r_pow[k] <= w_pow[k];
      end
`ifdef EXP_SAT_EN
      r_ovf[0] <= 1'b0;
      for (int unsigned k = 1; k <= TERMS; k++) begin
        r_ovf[k] <= w_ov[k];
      end
`endif
    end
  end

  assign out_valid = r_vld[TERMS];
  assign out_data  = r_vld[TERMS] ? r_sum[TERMS] : '0;
  assign out_tag   = r_vld[TERMS] ? r_tag[TERMS] : '0;
`ifdef EXP_SAT_EN
  assign out_overflow = r_vld[TERMS] & r_ovf[TERMS];
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_exp_taylor_pipe.sv
// Testbench for exp_taylor_pipe (W=16, F=12, TERMS=8, TAG_W=4).
// A scoreboard queue receives the expected result, from a bit-exact
// software model, when an operand is accepted. The entry is compared when
// the result leaves the unit.
module tb_exp_taylor_pipe;
  localparam int W     = 16;
  localparam int F     = 12;
  localparam int TERMS = 8;
  localparam int TAG_W = 4;
`ifdef EXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_x = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_overflow;

  always #5 clk = ~clk;

  exp_taylor_pipe #(.W(W), .F(F), .TERMS(TERMS), .TAG_W(TAG_W)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_overflow (out_overflow)
  );

  typedef struct packed {
    logic [W-1:0]     d;
    logic [TAG_W-1:0] t;
    logic             o;
  } exp_t;

  exp_t             sb[$];
  int               stim_x[$];
  logic [TAG_W-1:0] stim_t[$];
  logic [W-1:0]     got_data[$];
  logic             got_ovf[$];
  int               got_cyc[$];
  int               acc_cyc[$];
  int               inready_drops;
  int               n_vec = 0;
  int               n_err = 0;

  // round(4096 / k!) for k = 1..8
  localparam longint RECIP [1:8] = '{4096, 2048, 683, 171, 34, 6, 1, 0};

  function automatic longint fit16(input longint v, output bit ov);
    logic [15:0] lo;
    ov = 1'b0;
    if (SAT) begin
      if (v > 32767)  begin ov = 1'b1; return 32767;  end
      if (v < -32768) begin ov = 1'b1; return -32768; end
      return v;
    end
    lo = v[15:0];
    return longint'($signed(lo));
  endfunction

  function automatic exp_t model(input int x, input logic [TAG_W-1:0] tag);
    longint pow, sum, term;
    bit     ov, of;
    exp_t   e;
    pow = 4096;
    sum = 4096;
    of  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pow  = fit16((pow * x) >>> 12, ov);         of |= ov;
      term = fit16((pow * RECIP[k]) >>> 12, ov);  of |= ov;
      sum  = fit16(sum + term, ov);               of |= ov;
    end
    e.d = sum[15:0];
    e.t = tag;
    e.o = of;
    return e;
  endfunction

  // Scoreboard engine: drives the stim queues, checks every popped result,
  // and checks that held outputs stay stable during a stall.
  task automatic run_stream(input bit rnd, input int budget);
    int               sent;
    bit               hold_v;
    logic [W-1:0]     hold_d;
    logic [TAG_W-1:0] hold_t;
    exp_t             e;
    sent = 0;
    hold_v = 1'b0;
    hold_d = '0;
    hold_t = '0;
    sb.delete(); got_data.delete(); got_ovf.delete();
    got_cyc.delete(); acc_cyc.delete();
    inready_drops = 0;
    for (int cyc = 0; cyc < budget && (sent < stim_x.size() || sb.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid  = (sent < stim_x.size()) && (!rnd || $urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_x   = W'(stim_x[sent]);
        in_tag = stim_t[sent];
      end
      #1;
      if (hold_v) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_tag !== hold_t) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b d=%0d t=%0d exp v=1 d=%0d t=%0d",
                   out_valid, out_data, out_tag, hold_d, hold_t);
        end
      end
      if (in_valid && !in_ready) inready_drops++;
      if (in_valid && in_ready) begin
        sb.push_back(model(stim_x[sent], stim_t[sent]));
        acc_cyc.push_back(cyc + 1);
        sent++;
      end
      hold_v = 1'b0;
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_out: got d=%0d t=%0d exp no result", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_tag !== e.t || out_overflow !== e.o) begin
            n_err++;
            $display("FAIL result: got d=%0d t=%0d o=%0b exp d=%0d t=%0d o=%0b",
                     out_data, out_tag, out_overflow, e.d, e.t, e.o);
          end
          got_data.push_back(out_data);
          got_ovf.push_back(out_overflow);
          got_cyc.push_back(cyc);
        end
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_d = out_data;
        hold_t = out_tag;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (sb.size() != 0 || sent != stim_x.size()) begin
      n_err++;
      $display("FAIL stream_timeout: got pending=%0d unsent=%0d exp 0 0",
               sb.size(), stim_x.size() - sent);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 ||
        out_overflow !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b d=%0d t=%0d o=%0b rdy=%0b exp 0 0 0 0 1",
               out_valid, out_data, out_tag, out_overflow, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_zero();
    stim_x.delete(); stim_t.delete();
    stim_x.push_back(0); stim_t.push_back(4'd5);
    run_stream(1'b0, 40);
    n_vec++;
    if (got_data.size() != 1 || got_data[0] !== 16'd4096 || got_ovf[0] !== 1'b0 ||
        got_cyc[0] - acc_cyc[0] != TERMS) begin
      n_err++;
      $display("FAIL zero_latency: got n=%0d d=%0d lat=%0d exp n=1 d=4096 lat=%0d",
               got_data.size(), got_data[0], got_cyc[0] - acc_cyc[0], TERMS);
    end
  endtask

  task automatic test_known();
    int d;
    stim_x.delete(); stim_t.delete();
    stim_x.push_back(4096);   stim_t.push_back(4'd1);
    stim_x.push_back(-4096);  stim_t.push_back(4'd2);
    stim_x.push_back(12288);  stim_t.push_back(4'd3);
    stim_x.push_back(-12288); stim_t.push_back(4'd4);
    stim_x.push_back(20000);  stim_t.push_back(4'd6);
    run_stream(1'b0, 60);
    d = int'($signed(got_data[0])) - 11134;
    n_vec++;
    if (d < -2 || d > 2) begin
      n_err++;
      $display("FAIL exp_one: got %0d exp 11134+-2", $signed(got_data[0]));
    end
    d = int'($signed(got_data[1])) - 1507;
    n_vec++;
    if (d < -2 || d > 2) begin
      n_err++;
      $display("FAIL exp_minus_one: got %0d exp 1507+-2", $signed(got_data[1]));
    end
    n_vec++;
`ifdef EXP_SAT_EN
    if (got_data[2] !== 16'd32767 || got_ovf[2] !== 1'b1) begin
      n_err++;
      $display("FAIL exp_three_sat: got d=%0d o=%0b exp d=32767 o=1", got_data[2], got_ovf[2]);
    end
`else
    if (got_ovf[2] !== 1'b0) begin
      n_err++;
      $display("FAIL exp_three_wrap: got o=%0b exp o=0", got_ovf[2]);
    end
`endif
  endtask

  task automatic test_stall_stream();
    stim_x.delete(); stim_t.delete();
    for (int i = 0; i < 20; i++) begin
      stim_x.push_back(int'($urandom_range(0, 16383)) - 8192);
      stim_t.push_back(TAG_W'(i % 16));
    end
    run_stream(1'b1, 400);
    n_vec++;
    if (got_data.size() != 20) begin
      n_err++;
      $display("FAIL stream_count: got %0d exp 20", got_data.size());
    end
  endtask

  task automatic test_back_to_back();
    int gaps;
    stim_x.delete(); stim_t.delete();
    for (int i = 0; i < 16; i++) begin
      stim_x.push_back(i * 700 - 5000);
      stim_t.push_back(TAG_W'(15 - i));
    end
    run_stream(1'b0, 60);
    n_vec++;
    if (inready_drops != 0) begin
      n_err++;
      $display("FAIL b2b_in_ready: got drops=%0d exp 0", inready_drops);
    end
    n_vec++;
    if (got_cyc.size() != 16 || got_cyc[0] - acc_cyc[0] != TERMS) begin
      n_err++;
      $display("FAIL b2b_fill: got n=%0d lat=%0d exp n=16 lat=%0d",
               got_cyc.size(), got_cyc[0] - acc_cyc[0], TERMS);
    end
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    n_vec++;
    if (gaps != 0) begin
      n_err++;
      $display("FAIL b2b_rate: got gaps=%0d exp 0", gaps);
    end
  endtask

  task automatic test_reset_flight();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = W'(i * 1000);
      in_tag   = TAG_W'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    n_vec++;
    if (seen != 1) begin
      n_err++;
      $display("FAIL flight_fill: got out_valid=0 exp 1 within 30 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b d=%0d t=%0d rdy=%0b exp 0 0 0 1",
               out_valid, out_data, out_tag, in_ready);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        n_err++;
        $display("FAIL post_reset_idle: cycle %0d got v=%0b d=%0d exp 0 0",
                 c, out_valid, out_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_stall_stream();
    test_back_to_back();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish exp finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/exp_taylor_pipe.md
# exp_taylor_pipe

Parametrised, fully pipelined fixed-point exponential unit for the systolic attention datapath. It computes exp(x) by a truncated Taylor series, with one series term per pipeline stage. It accepts one operand per cycle under a valid/ready handshake and carries a side-band tag, so the softmax stage can interleave rows and channels. It sits between the score-scaling stage and the softmax normaliser and replaces the single-term processing element used so far.

## Interface
Parameters:
- W, 16: operand/result width, signed two's complement fixed point, legal 8..32.
- F, 12: fractional bits, legal 1..W-2.
- TERMS, 8: number of series terms (k = 1..TERMS), equal to the pipeline depth, legal 2..12.
- TAG_W, 4: side-band tag width, legal 1..16.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  unit accepts operand this cycle.
- in_x  in  W  operand x, Q(W-F).F.
- in_tag  in  TAG_W  tag travelling with operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  exp(x) approximation, same Q format.
- out_tag  out  TAG_W  tag of the result.
- out_overflow  out  1  result was clamped (only meaningful with EXP_SAT_EN).

## Operation
- Stage 0 (accept) loads x, pow = 1.0 (1<<F), sum = 1.0, tag, and valid.
- Stage k (1..TERMS) computes three values:
  - pow_k = (pow_{k-1} * x) >>> F, using a 2W-bit product and an arithmetic shift (floor).
  - term_k = (pow_k * RECIP[k]) >>> F.
  - sum_k = sum_{k-1} + term_k.
- x, tag, and the overflow flag pass through each stage.
- RECIP[k] = floor(2^F / k! + 0.5). It is an elaboration-time constant computed with 64-bit integers; no runtime ROM.
- The result of the last stage drives out_* directly from registers.
- Width fitting of pow_k, term_k, and sum_k to W bits follows Configuration.
- Global-stall pipeline: stall = out_valid && !out_ready.
  - When stall is high, every stage holds.
  - When stall is low, every stage advances and bubbles (valid = 0) propagate.
- in_ready = !stall, a combinational path from out_ready. A transfer occurs when in_valid && in_ready.
- Results leave in input order with no drop and no duplication. Bubbles never produce out_valid.
- Data registers of invalid stages may hold anything. Only out_data, out_tag, and out_overflow are forced to 0 when out_valid = 0.

## Timing
- Latency: an operand accepted at edge n appears with out_valid = 1 after edge n+TERMS when there is no stall. Each stall cycle adds one cycle.
- Throughput is 1 result per cycle while out_ready = 1.
- Reset (reset_n low) acts asynchronously. It clears all stage valids, data, tags, and flags to 0. While reset_n is low: out_valid = 0, out_data = 0, out_tag = 0, out_overflow = 0, in_ready = 1.
- Reset mid-operation discards all in-flight operands; nothing is emitted after release.
- Reset release is synchronised by the integrator; the first transfer may occur on the first edge after release.
- Simultaneous input accept and output pop in the same cycle is legal and keeps the pipeline full.
- out_valid and out_data stay stable while out_valid && !out_ready.

## Configuration
- EXP_SAT_EN defined:
  - Every fit of pow_k, term_k, and sum_k to W bits clamps to [-2^(W-1), 2^(W-1)-1].
  - Any clamp sets a per-operand sticky flag that propagates to out_overflow.
- EXP_SAT_EN undefined:
  - Fits truncate to the low W bits (wrap).
  - out_overflow is tied to 0 and the flag registers are not built.

## Test plan
(All scenarios use W=16, F=12, TERMS=8, and compare against a bit-exact software model.)
- x=0, out_ready=1 -> out_data=4096 (1.0) exactly, 8 cycles after accept, out_overflow=0.
- x=4096 (1.0) -> out_data=11134±2 LSB (e); x=-4096 -> 1507±2 LSB.
- x=12288 (3.0) with EXP_SAT_EN -> out_data=32767, out_overflow=1. The same operand without the macro -> the model's wrapped value, out_overflow=0.
- Stream of 20 operands, tags 0..15 cycling, out_ready toggling pseudo-randomly -> 20 results in order with matching tags, out_data stable during stalls, no loss or duplication.
- Back-to-back stream with out_ready=1 -> in_ready stays 1 and one result per cycle after an 8-cycle fill.
- reset_n pulsed low with 5 operands in flight -> out_valid drops to 0 immediately. After release and 20 idle cycles, out_valid never asserts.
